wgr_bus_trace: RTL and testbench

Parametrised debug-output engine for the RV32I core and memory pair, replacing the fixed "address low byte on the bidir pins" debug view. It snoops completed memory transactions, buffers them in a FIFO, and serialises them as framed beats on an OUT_W-bit port with a ready/valid handshake. Mode 0 reproduces the legacy registered address passthrough. It sits in the top level between the CPU/memory bus and the uio pads.

---
 rtl/wgr_bus_trace.sv | 208 ++++++++++++++++++++
 tb/tb_wgr_bus_trace.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wgr_bus_trace.sv
// Snoops completed CPU memory transactions into a FIFO and serialises them as framed OUT_W-bit beats.
// Entry popped one edge after capture; beats advance only on valid&ready, outputs hold while ready is low.

module wgr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_dat,
  output logic [W-1:0]               rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
endmodule

module wgr_bus_trace #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int OUT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_write_data,
  input  logic [DATA_W-1:0]          mem_read_data,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic                       mem_busy,
  input  logic [1:0]                 mode,
  input  logic                       trace_en,
  input  logic                       trace_ready,
  output logic [OUT_W-1:0]           trace_out,
  output logic                       trace_valid,
  output logic                       trace_frame,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int NA = ADDR_W / OUT_W;
  localparam int ND = DATA_W / OUT_W;
  localparam int BW = $clog2(NA + ND + 1);
  localparam int SW = ADDR_W + DATA_W;

  typedef struct packed {
    logic              wr;
    logic [4:0]        seq;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {S_IDLE, S_LOAD} st_t;

  st_t             state, state_nx;
  logic            active, evt, push, pop, drop;
  logic            full, empty, drop_q, last;
  logic [4:0]      seq_q;
  entry_t          wr_ent, rd_ent;
  logic [SW-1:0]   rest_q;
  logic [BW-1:0]   beats_q;
  logic [OUT_W-1:0] hdr;

  assign active = trace_en && (mode == 2'd1 || mode == 2'd2);
  assign evt    = (mem_read || mem_write) && !mem_busy;
  assign last   = (beats_q == '0);
  assign push   = active && evt && (!full || pop);
  assign drop   = active && evt && full && !pop;

  always_comb begin
    wr_ent      = '0;
    wr_ent.wr   = mem_write;
    wr_ent.seq  = seq_q;
    wr_ent.addr = mem_addr;
    wr_ent.data = mem_write ? mem_write_data : mem_read_data;
  end

  wgr_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!active),
    .push   (push),
    .pop    (pop),
    .wr_dat (wr_ent),
    .rd_dat (rd_ent),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  // Popping on the last accepted beat keeps frames back-to-back.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    if (!active) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = S_LOAD;
          end
        end
        S_LOAD: begin
          if (trace_ready && last) begin
            if (!empty) pop = 1'b1;
            else        state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hdr      = '0;
    hdr[7]   = 1'b1;
    hdr[6]   = rd_ent.wr;
    hdr[5]   = drop_q;
    hdr[4:0] = rd_ent.seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // A drop on the edge that reports the previous one keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      drop_q <= 1'b0;
    end else if (!active) begin
      seq_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (evt) seq_q <= seq_q + 5'd1;
      if (drop)                drop_q <= 1'b1;
      else if (pop && drop_q)  drop_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_out   <= '0;
      trace_valid <= 1'b0;
      trace_frame <= 1'b0;
      rest_q      <= '0;
      beats_q     <= '0;
    end else if (!active) begin
      trace_valid <= 1'b0;
      trace_frame <= 1'b0;
      trace_out   <= (mode == 2'd0) ? mem_addr[OUT_W-1:0] : '0;
    end else if (pop) begin
      trace_out   <= hdr;
      trace_valid <= 1'b1;
      trace_frame <= 1'b1;
      rest_q      <= {rd_ent.data, rd_ent.addr};
      beats_q     <= (mode == 2'd2) ? BW'(NA + ND) : BW'(NA);
    end else if (state == S_LOAD && trace_ready) begin
      trace_frame <= 1'b0;
      if (last) begin
        trace_valid <= 1'b0;
      end else begin
        trace_out <= rest_q[OUT_W-1:0];
        rest_q    <= rest_q >> OUT_W;
        beats_q   <= beats_q - BW'(1);
      end
    end
  end

  assign overflow = drop_q;
endmodule

// File: tb/tb_wgr_bus_trace.sv
// Directed and randomized checks of wgr_bus_trace against a beat-list scoreboard.
module tb_wgr_bus_trace;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, mem_busy;
  logic [1:0]  mode;
  logic        trace_en, trace_ready;
  logic [7:0]  trace_out;
  logic        trace_valid, trace_frame, overflow;
  logic [3:0]  fifo_level;

  wgr_bus_trace #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_busy(mem_busy), .mode(mode), .trace_en(trace_en), .trace_ready(trace_ready),
    .trace_out(trace_out), .trace_valid(trace_valid), .trace_frame(trace_frame),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic f; logic l; } beat_t;
  beat_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  int frames_done = 0, issued = 0, seq_m = 0;
  bit sb_on = 1'b1;

  logic [7:0] t1 [9]  = '{8'hC0, 8'h34, 8'h12, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] t2 [10] = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h81, 8'h44, 8'h00, 8'h00, 8'h00};
  logic [7:0] t3 [10] = '{8'h82, 8'h00, 8'h01, 8'h00, 8'h00, 8'h83, 8'h04, 8'h01, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_lit(input logic [7:0] b, input logic f, input logic l);
    beat_t e;
    e.d = b; e.f = f; e.l = l;
    exp_q.push_back(e);
  endtask

  // Reference frame: header byte then address bytes, then data bytes in mode 2, LSB first.
  task automatic exp_frame(input logic wr, input int seq, input logic [31:0] a,
                           input logic [31:0] d, input logic m2, input logic drp);
    logic [7:0]  hb;
    logic [63:0] body;
    int nb;
    hb = 8'h80 | (wr ? 8'h40 : 8'h00) | (drp ? 8'h20 : 8'h00) | 8'(seq % 32);
    body = {d, a};
    nb = m2 ? 8 : 4;
    push_lit(hb, 1'b1, 1'b0);
    for (int i = 0; i < nb; i++)
      push_lit(8'((body >> (8 * i)) & 64'hFF), 1'b0, i == nb - 1);
  endtask

  task automatic tick();
    logic acc, f;
    logic [7:0] b;
    beat_t e;
    int sz;
    acc = trace_valid && trace_ready;
    b = trace_out;
    f = trace_frame;
    @(posedge clk);
    #1;
    if (acc && sb_on) begin
      sz = exp_q.size();
      chk("beat_expected", sz > 0, 1);
      if (sz > 0) begin
        e = exp_q.pop_front();
        chk("beat_dat", b, e.d);
        chk("beat_frm", f, e.f);
        if (e.l) frames_done++;
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    trace_ready = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_mode3();
    mode = 2'd3;
    tick();
  endtask

  initial begin
    bit found;
    logic wr;
    int r;
    rst_n = 1'b0; mem_addr = '0; mem_write_data = '0; mem_read_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_busy = 1'b0;
    mode = 2'd0; trace_en = 1'b0; trace_ready = 1'b0;
    #12;
    chk("rst_out", trace_out, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_frame", trace_frame, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", fifo_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write in mode 2
    mode = 2'd2; trace_en = 1'b1; trace_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) push_lit(t1[i], i == 0, i == 8);
    mem_write = 1'b1; mem_addr = 32'h0000_1234; mem_write_data = 32'hDEAD_BEEF;
    tick();
    mem_write = 1'b0;
    chk("t1_lat_valid0", trace_valid, 0);
    chk("t1_level1", fifo_level, 1);
    tick();
    chk("t1_hdr_valid", trace_valid, 1);
    chk("t1_hdr_frame", trace_frame, 1);
    chk("t1_hdr_dat", trace_out, 8'hC0);
    drain(15);
    clear_mode3();
    chk("m3_out_zero", trace_out, 0);

    // Two back-to-back reads in mode 1
    mode = 2'd1;
    for (int i = 0; i < 10; i++) push_lit(t2[i], i == 0 || i == 5, i == 4 || i == 9);
    mem_read = 1'b1; mem_addr = 32'h40; tick();
    mem_addr = 32'h44; tick();
    mem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_no_gap", trace_valid, 1);
      tick();
    end
    chk("t2_done_valid", trace_valid, 0);

    // Multi-cycle access yields one frame, seq advances by one
    for (int i = 0; i < 10; i++) push_lit(t3[i], i == 0 || i == 5, i == 4 || i == 9);
    mem_read = 1'b1; mem_busy = 1'b1; mem_addr = 32'h100;
    tick(); tick(); tick();
    mem_busy = 1'b0; tick();
    mem_read = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    mem_read = 1'b1; mem_addr = 32'h104; tick();
    mem_read = 1'b0;
    drain(15);
    for (int i = 0; i < 4; i++) tick();

    // Overflow with ready held low
    clear_mode3();
    mode = 2'd1; trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_read = 1'b1; mem_addr = 32'h1000 + 32'(i * 4);
      if (i < 9) exp_frame(1'b0, i, mem_addr, 32'h0, 1'b0, i == 1);
      tick();
    end
    mem_read = 1'b0;
    chk("t4_level8", fifo_level, 8);
    chk("t4_ovf", overflow, 1);
    tick();
    chk("t4_hold_dat", trace_out, 8'h80);
    chk("t4_hold_valid", trace_valid, 1);
    chk("t4_hold_frame", trace_frame, 1);
    trace_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (trace_valid && trace_frame && trace_out == 8'hA1) found = 1'b1;
      else begin
        chk("t4_ovf_held", overflow, 1);
        tick();
      end
    end
    chk("t4_a1_seen", found, 1);
    chk("t4_ovf_cleared", overflow, 0);
    drain(100);
    chk("t4_level0", fifo_level, 0);

    // Mode 0 registered passthrough
    mode = 2'd0;
    mem_addr = 32'h1234_565A; tick();
    chk("t5_pass", trace_out, 8'h5A);
    chk("t5_pass_valid", trace_valid, 0);
    mem_addr = 32'h1234_56C3;
    chk("t5_registered", trace_out, 8'h5A);
    tick();
    chk("t5_pass2", trace_out, 8'hC3);

    // Leave mode 2 mid-frame
    sb_on = 1'b0;
    clear_mode3();
    mode = 2'd2;
    mem_write = 1'b1; mem_addr = 32'h11; tick();
    mem_addr = 32'h22; tick();
    mem_write = 1'b0;
    chk("t5_lvl_pre", fifo_level, 1);
    tick(); tick();
    chk("t5_midframe", trace_valid, 1);
    mem_addr = 32'h0000_0077; mode = 2'd0;
    tick();
    chk("t5_sw_valid", trace_valid, 0);
    chk("t5_sw_frame", trace_frame, 0);
    chk("t5_sw_level", fifo_level, 0);
    chk("t5_sw_out", trace_out, 8'h77);
    mode = 2'd2;
    tick(); tick();
    chk("t5_not_resumed", trace_valid, 0);

    // Asynchronous reset mid-frame
    mem_write = 1'b1; mem_addr = 32'hCAFE_0001; mem_write_data = 32'h5; tick();
    mem_write = 1'b0;
    tick(); tick();
    chk("t6_pre_valid", trace_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", trace_out, 0);
    chk("t6_rst_valid", trace_valid, 0);
    chk("t6_rst_frame", trace_frame, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_level", fifo_level, 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;
    mem_write = 1'b1; mem_addr = 32'hA5A5_0010; mem_write_data = 32'h0F0F;
    exp_frame(1'b1, 0, mem_addr, mem_write_data, 1'b1, 1'b0);
    tick();
    mem_write = 1'b0;
    for (int i = 0; i < 8 && !trace_valid; i++) tick();
    chk("t6_seen", trace_valid, 1);
    chk("t6_hdr_seq0", trace_out, 8'hC0);
    drain(20);

    // Randomized traffic with backpressure, one fixed mode per run
    for (int m = 1; m <= 2; m++) begin
      clear_mode3();
      mode = 2'(m);
      seq_m = 0; issued = 0; frames_done = 0;
      for (int c = 0; c < 400; c++) begin
        trace_ready = ($urandom_range(0, 3) != 0);
        mem_read = 1'b0; mem_write = 1'b0; mem_busy = 1'b0;
        mem_addr = $urandom; mem_write_data = $urandom; mem_read_data = $urandom;
        if (issued - frames_done < 8 && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 3);
          mem_read  = (r == 0 || r == 2 || r == 3);
          mem_write = (r == 1 || r == 2);
          mem_busy  = (r == 3);
          if (!mem_busy) begin
            wr = mem_write;
            exp_frame(wr, seq_m, mem_addr, wr ? mem_write_data : mem_read_data, m == 2, 1'b0);
            seq_m = (seq_m + 1) % 32;
            issued++;
          end
        end
        tick();
        chk("rand_no_ovf", overflow, 0);
      end
      drain(400);
      chk("rand_level0", fifo_level, 0);
      chk("rand_frames", frames_done, issued);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
